// File: rtl/mux16_pkg.sv
// Shared constants, FSM state type and lane decode helper for the 16:1 TDM multiplexer.
package mux16_pkg;
    localparam int LANES = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
        lane_onehot = LANES'(1) << sel;
    endfunction
endpackage

// File: rtl/mux_16x1_tdm_rr_pick16.sv
// Combinational lane search: round-robin from last+1, or lowest index when
// MUX16_FIXED_PRIORITY_EN is defined.
module rr_pick16
    import mux16_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

`ifdef MUX16_FIXED_PRIORITY_EN
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (req[i]) idx = SEL_W'(i);
        end
    end
`else
    logic [SEL_W-1:0] lane;

    // Walk the ring backwards so the closest requester after last wins; k=16 revisits last itself.
    always_comb begin
        found = |req;
        idx   = '0;
        lane  = '0;
        for (int k = LANES; k >= 1; k--) begin
            lane = last + SEL_W'(k);
            if (req[lane]) idx = lane;
        end
    end
`endif

endmodule

// File: rtl/mux_16x1_tdm.sv
// 16-lane to 1-bit time-division multiplexer with req/ack handshake per lane and
// valid/ready on the output. Arbitration set by MUX16_FIXED_PRIORITY_EN.
module mux_16x1_tdm
    import mux16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] A,
    input  logic [LANES-1:0] req,
    output logic [LANES-1:0] ack,
    output logic             Y,
    output logic [SEL_W-1:0] S,
    output logic             Y_valid,
    input  logic             Y_ready,
    output logic [CNT_W-1:0] count
);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] last;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    rr_pick16 u_pick (
        .req   (req),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        Y_valid   = 1'b0;
        ack       = '0;
        case (state)
            IDLE: if (pick_found) state_nxt = SEND;
            SEND: begin
                Y_valid = 1'b1;
                if (Y_ready) state_nxt = ACK;
            end
            ACK: begin
                ack       = lane_onehot(S);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latches the lane in IDLE; completion bookkeeping happens on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            Y     <= 1'b0;
            S     <= '0;
            count <= '0;
            last  <= SEL_W'(LANES - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_found) begin
                S <= pick_idx;
                Y <= A[pick_idx];
            end
            if (state == SEND && Y_ready) begin
                count <= count + 1'b1;
                last  <= S;
            end
        end
    end

endmodule
